fetch_unit: RTL and testbench

Instruction-fetch front end and IF/ID pipeline register of the pipelined RISC-V core. It consumes the `stall_if`, `stall_id`, `flush_branch` and `flush_jump` controls from the hazard unit and turns them into PC hold/redirect, instruction-memory request gating, in-flight response kill, and IF/ID hold/bubble behaviour. It sits between the synchronous instruction memory and the decode stage.

---
 rtl/fetch_unit.sv | 219 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end plus IF/ID pipeline register for the RISC-V core.
// Latency: request in cycle n, instruction in imem_rdata in n+1, visible on id_* in n+2.
// Backpressure: stall_if/stall_id hold the PC and gate new fetches; a response caught by
//   stall_id is parked in a one-entry hold buffer. A flush redirects the PC and kills the
//   in-flight response.
//
// Ports:
//   clk, rst_n                     core clock, async active-low reset
//   stall_if, stall_id             hazard-unit holds for PC / IF-ID register
//   flush_branch, flush_jump       redirects; branch has priority (older instruction)
//   branch_target, jump_target     redirect PCs
//   imem_req, imem_addr            fetch request to the synchronous instruction memory
//   imem_rdata                     instruction for last cycle's request (fixed 1-cycle latency)
//   id_valid, id_pc, id_pc_plus4,
//   id_instr                       IF/ID register contents (NOP when not valid)
//   perf_*_cnt                     saturating counters, only when FETCH_PERF_CNT_EN is defined
//
// Build option: define FETCH_PERF_CNT_EN to add the fetch/stall/flush performance counters.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush_branch,
  input  logic              flush_jump,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       jump_target,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc_plus4,
  output logic [31:0]       id_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_fetch_cnt,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("fetch_unit: CNT_W must be at least 1");
  end

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] pc_q;
  logic        rsp_vld_q;
  logic [31:0] rsp_pc_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_instr_q;
  logic        id_valid_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_instr_q;

  logic        flush;
  logic [31:0] redirect_pc;
  logic        id_load_rsp;
  logic        id_load_hold;
  logic        hold_load;

  assign flush       = flush_branch | flush_jump;
  // Branch resolves in EX, which is older than the jump in ID, so it wins.
  assign redirect_pc = flush_branch ? branch_target : jump_target;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. HOLD is entered only when a response lands while ID is
  // stalled; only one request is ever in flight, so one buffer entry suffices.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (stall_id && rsp_vld_q) state_d = HOLD;
        HOLD:    if (!stall_id)             state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / datapath controls. Flush overrides both stalls.
  // rst_n gates the request so memory sees nothing while reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req     = 1'b0;
    id_load_rsp  = 1'b0;
    id_load_hold = 1'b0;
    hold_load    = 1'b0;
    if (!flush) begin
      case (state_q)
        RUN: begin
          imem_req    = rst_n & ~stall_if & ~stall_id;
          id_load_rsp = ~stall_id;
          hold_load   = stall_id & rsp_vld_q;
        end
        HOLD: begin
          // Releasing the held instruction uses the cycle; fetch resumes next cycle.
          id_load_hold = ~stall_id;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc_q;

  // ---------------------------------------------------------------------------
  // PC and in-flight tag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      rsp_vld_q <= 1'b0;
      rsp_pc_q  <= 32'h0;
    end else begin
      // The tag always describes the request issued in the cycle just ended;
      // a flush cycle never issues, so the tag is cleared on flush as well.
      rsp_vld_q <= imem_req;
      if (flush) begin
        pc_q <= redirect_pc;
      end else if (imem_req) begin
        pc_q     <= pc_q + 32'd4;
        rsp_pc_q <= pc_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hold buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_pc_q    <= 32'h0;
      hold_instr_q <= NOP;
    end else if (flush) begin
      hold_pc_q    <= 32'h0;
      hold_instr_q <= NOP;
    end else if (hold_load) begin
      hold_pc_q    <= rsp_pc_q;
      hold_instr_q <= imem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register. Bubbles carry PC 0 and a NOP so decode sees a clean slot.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_instr_q <= NOP;
    end else if (flush || (id_load_rsp && !rsp_vld_q)) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_instr_q <= NOP;
    end else if (id_load_rsp) begin
      id_valid_q <= 1'b1;
      id_pc_q    <= rsp_pc_q;
      id_instr_q <= imem_rdata;
    end else if (id_load_hold) begin
      id_valid_q <= 1'b1;
      id_pc_q    <= hold_pc_q;
      id_instr_q <= hold_instr_q;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_q + 32'd4;
  assign id_instr    = id_instr_q;

`ifdef FETCH_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic stall_evt;
  assign stall_evt = (stall_if | stall_id) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (imem_req  && (perf_fetch_cnt != '1)) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (stall_evt && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (flush     && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one table row per clock cycle, plus hand-written
// async-reset and counter-saturation sequences.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_if, stall_id, flush_branch, flush_jump;
  logic [31:0] branch_target, jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc, id_pc_plus4, id_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [3:0]  perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100), .CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .flush_branch  (flush_branch),
    .flush_jump    (flush_jump),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_pc_plus4   (id_pc_plus4),
    .id_instr      (id_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction content is a recognisable function of its address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[23:0], 8'h33};
  endfunction

  // Synchronous instruction memory, 1-cycle latency; garbage when not requested.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? instr_of(imem_addr) : 32'hDEAD_BEEF;
  end

  typedef struct {
    bit          si, sd, fb, fj;
    logic [31:0] bt, jt;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit si, bit sd, bit fb, bit fj, logic [31:0] bt, logic [31:0] jt,
                              bit req, logic [31:0] addr, bit vld, logic [31:0] pc);
    vec_t v;
    v.si = si; v.sd = sd; v.fb = fb; v.fj = fj; v.bt = bt; v.jt = jt;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},    {31'b0, imem_req}, 32'h0);
    chk({tag, "_addr"},   imem_addr,         32'h100);
    chk({tag, "_vld"},    {31'b0, id_valid}, 32'h0);
    chk({tag, "_pc"},     id_pc,             32'h0);
    chk({tag, "_pc4"},    id_pc_plus4,       32'h4);
    chk({tag, "_instr"},  id_instr,          NOP);
  endtask

  // Called at posedge+1: drive the cycle's inputs, check, advance to the next cycle.
  task automatic run_row(input vec_t v, input string tag);
    stall_if      = v.si;
    stall_id      = v.sd;
    flush_branch  = v.fb;
    flush_jump    = v.fj;
    branch_target = v.bt;
    jump_target   = v.jt;
    #1;
    chk({tag, "_req"},  {31'b0, imem_req}, {31'b0, v.req});
    chk({tag, "_addr"}, imem_addr,         v.addr);
    chk({tag, "_vld"},  {31'b0, id_valid}, {31'b0, v.vld});
    if (v.vld) begin
      chk({tag, "_pc"},    id_pc,       v.pc);
      chk({tag, "_pc4"},   id_pc_plus4, v.pc + 32'd4);
      chk({tag, "_instr"}, id_instr,    instr_of(v.pc));
    end else begin
      chk({tag, "_instr"}, id_instr,    NOP);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall_if = 0; stall_id = 0; flush_branch = 0; flush_jump = 0;
    branch_target = 0; jump_target = 0;

    //          si sd fb fj  bt          jt         req addr     vld pc
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h100, 0, 0));        // c0
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h104, 0, 0));        // c1
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h108, 1, 32'h100));  // c2
    tv.push_back(mk(1,1,0,0, 0,          0,          0, 32'h10C, 1, 32'h104));  // c3 108 -> hold
    tv.push_back(mk(1,1,0,0, 0,          0,          0, 32'h10C, 1, 32'h104));  // c4
    tv.push_back(mk(1,1,0,0, 0,          0,          0, 32'h10C, 1, 32'h104));  // c5
    tv.push_back(mk(0,0,0,0, 0,          0,          0, 32'h10C, 1, 32'h104));  // c6 release, no fetch
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h10C, 1, 32'h108));  // c7 held instr
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h110, 0, 0));        // c8 bubble
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h114, 1, 32'h10C));  // c9
    tv.push_back(mk(0,0,1,0, 32'h200,    32'h500,    0, 32'h118, 1, 32'h110));  // c10 branch, kills 114
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h200, 0, 0));        // c11
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h204, 0, 0));        // c12
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h208, 1, 32'h200));  // c13
    tv.push_back(mk(0,0,1,1, 32'h300,    32'h400,    0, 32'h20C, 1, 32'h204));  // c14 both flushes
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h300, 0, 0));        // c15
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h304, 0, 0));        // c16
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h308, 1, 32'h300));  // c17
    tv.push_back(mk(0,1,0,0, 0,          0,          0, 32'h30C, 1, 32'h304));  // c18 308 -> hold
    tv.push_back(mk(0,1,0,0, 0,          0,          0, 32'h30C, 1, 32'h304));  // c19
    tv.push_back(mk(0,1,0,1, 32'hBAD0,   32'h400,    0, 32'h30C, 1, 32'h304));  // c20 jump in HOLD
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h400, 0, 0));        // c21
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h404, 0, 0));        // c22 308 dropped
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h408, 1, 32'h400));  // c23
    tv.push_back(mk(1,0,0,0, 0,          0,          0, 32'h40C, 1, 32'h404));  // c24 stall_if only
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h40C, 1, 32'h408));  // c25
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h410, 0, 0));        // c26
    tv.push_back(mk(0,0,0,0, 0,          0,          1, 32'h414, 1, 32'h40C));  // c27
    tv.push_back(mk(1,1,0,0, 0,          0,          0, 32'h418, 1, 32'h410));  // c28 414 -> hold

    // Reset state while rst_n is held low.
    repeat (2) @(posedge clk);
    #2;
    chk_reset_outputs("rst");

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < tv.size(); i++) begin
      run_row(tv[i], $sformatf("c%0d", i));
    end

    // Async reset in the middle of a HOLD stall.
    stall_if = 1; stall_id = 1;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_row(mk(0,0,0,0, 0, 0, 1, 32'h100, 0, 0),       "r0");
    run_row(mk(0,0,0,0, 0, 0, 1, 32'h104, 0, 0),       "r1");
    run_row(mk(0,0,0,0, 0, 0, 1, 32'h108, 1, 32'h100), "r2");

`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_3", {28'b0, perf_fetch_cnt}, 32'd3);
    repeat (17) @(posedge clk);
    #1;
    chk("perf_fetch_sat", {28'b0, perf_fetch_cnt}, 32'd15);
    chk("perf_stall",     {28'b0, perf_stall_cnt}, 32'd0);
    chk("perf_flush",     {28'b0, perf_flush_cnt}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
